sim_ctrl: RTL and testbench



---
 rtl/sim_ctrl_pkg.sv | 24 ++
 rtl/sim_chan_wdog.sv | 45 ++++
 rtl/sim_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sim_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_ctrl_pkg.sv
// Shared types and helpers for the simulation-control block.
package sim_ctrl_pkg;

  typedef enum logic [2:0] {
    RST_HOLD = 3'd0,
    RUN      = 3'd1,
    DRAIN    = 3'd2,
    PASS     = 3'd3,
    FAIL     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_TIMEOUT = 2'd1,
    FC_STALL   = 2'd2,
    FC_ERROR   = 2'd3
  } fail_code_t;

  // Channel index width; a single channel still gets a 1-bit field.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sim_chan_wdog.sv
// Per-channel watchdog: sticky done flag and a saturating count of cycles without progress.
module sim_chan_wdog #(
  parameter int IDLE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic progress,
  input  logic done,
  output logic done_q,
  output logic stalled
);

  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);

  logic [IDLE_W-1:0] idle_q;
  logic [IDLE_W-1:0] idle_d;
  logic              done_d;

  always_comb begin
    done_d = done_q | done;
    if (progress || done_d) begin
      idle_d = '0;
    end else if (idle_q == IDLE_MAX) begin
      idle_d = idle_q;
    end else begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  // Flags the cycle on which the idle run reaches its limit, so the fail lands one cycle later.
  assign stalled = en && !done_d && (idle_d == IDLE_MAX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      done_q <= 1'b0;
      idle_q <= '0;
    end else if (en) begin
      done_q <= done_d;
      idle_q <= idle_d;
    end
  end

endmodule

// File: rtl/sim_ctrl.sv
// Simulation control: stretched DUT reset, global timeout, per-channel stall watchdog
// and a single sticky pass/fail verdict with cause code and offending channel.
module sim_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int N_CH           = 2,
  parameter int RST_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int IDLE_CYCLES    = 1000,
  parameter int DRAIN_CYCLES   = 16,
  parameter int CNT_W          = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CH-1:0]             ch_progress,
  input  logic [N_CH-1:0]             ch_done,
  input  logic [N_CH-1:0]             ch_error,
  output logic                        dut_rst,
  output logic [2:0]                  state,
  output logic [CNT_W-1:0]            cycle_cnt,
  output logic                        finish,
  output logic                        pass,
  output logic [1:0]                  fail_code,
  output logic [ch_idx_w(N_CH)-1:0]   fail_ch
);

  localparam int CH_W    = ch_idx_w(N_CH);
  localparam int HOLD_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST    = HOLD_W'(RST_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST   = DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              state_q, state_d;
  fail_code_t          cause_code;
  logic [CH_W-1:0]     cause_ch;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                dut_rst_d, finish_d, pass_d, entering;
  logic [1:0]          fail_code_d;
  logic [CH_W-1:0]     fail_ch_d;

  logic                chan_en;
  logic [N_CH-1:0]     done_q, stalled;
  logic                done_all, err_any, stall_any;
  logic [CH_W-1:0]     err_idx, stall_idx;

  assign chan_en = (state_q == RUN) || (state_q == DRAIN);

  for (genvar i = 0; i < N_CH; i++) begin : gen_ch
    sim_chan_wdog #(
      .IDLE_CYCLES(IDLE_CYCLES)
    ) u_wdog (
      .clk      (clk),
      .rst      (rst),
      .en       (chan_en),
      .progress (ch_progress[i]),
      .done     (ch_done[i]),
      .done_q   (done_q[i]),
      .stalled  (stalled[i])
    );
  end

  assign done_all  = &(done_q | ch_done);
  assign err_any   = |ch_error;
  assign stall_any = |stalled;

  // Scanning downwards leaves the lowest flagged channel as the winner.
  always_comb begin
    err_idx   = '0;
    stall_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_error[i]) err_idx   = CH_W'(i);
      if (stalled[i])  stall_idx = CH_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RST_HOLD;
      hold_q    <= '0;
      drain_q   <= '0;
      cycle_cnt <= '0;
      dut_rst   <= 1'b0;
      finish    <= 1'b0;
      pass      <= 1'b0;
      fail_code <= FC_NONE;
      fail_ch   <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      drain_q   <= drain_d;
      cycle_cnt <= cnt_d;
      dut_rst   <= dut_rst_d;
      finish    <= finish_d;
      pass      <= pass_d;
      fail_code <= fail_code_d;
      fail_ch   <= fail_ch_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cause_code = FC_NONE;
    cause_ch   = '0;
    case (state_q)
      RST_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = RUN;
      end
      RUN: begin
        if (err_any) begin
          state_d    = FAIL;
          cause_code = FC_ERROR;
          cause_ch   = err_idx;
        end else if (stall_any) begin
          state_d    = FAIL;
          cause_code = FC_STALL;
          cause_ch   = stall_idx;
        end else if (cycle_cnt == TIMEOUT_LAST) begin
          state_d    = FAIL;
          cause_code = FC_TIMEOUT;
        end else if (done_all) begin
          state_d = (DRAIN_CYCLES == 0) ? PASS : DRAIN;
        end
      end
      DRAIN: begin
        // Stall and timeout are masked while draining; only errors can still fail the run.
        if (err_any) begin
          state_d    = FAIL;
          cause_code = FC_ERROR;
          cause_ch   = err_idx;
        end else if (drain_q == DRAIN_LAST) begin
          state_d = PASS;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    entering    = (state_d != state_q) && ((state_d == PASS) || (state_d == FAIL));
    dut_rst_d   = (state_d != RST_HOLD);
    finish_d    = entering;
    pass_d      = (state_d == PASS);
    fail_code_d = fail_code;
    fail_ch_d   = fail_ch;
    if (entering && (state_d == FAIL)) begin
      fail_code_d = cause_code;
      fail_ch_d   = cause_ch;
    end
    hold_d  = (state_q == RST_HOLD) ? hold_q + HOLD_W'(1) : hold_q;
    drain_d = (state_q == DRAIN) ? drain_q + DRAIN_W'(1) : '0;
    cnt_d   = cycle_cnt;
    if (chan_en && (cycle_cnt != '1)) cnt_d = cycle_cnt + CNT_W'(1);
  end

  assign state = state_q;

endmodule

// File: tb/tb_sim_ctrl.sv
// Bench for sim_ctrl: directed scenarios and randomized runs, every cycle compared
// against a behavioural model of the run/verdict rules.
module tb_sim_ctrl;
  import sim_ctrl_pkg::*;

  localparam int N_CH           = 3;
  localparam int RST_CYCLES     = 8;
  localparam int TIMEOUT_CYCLES = 200;
  localparam int IDLE_CYCLES    = 20;
  localparam int DRAIN_CYCLES   = 16;
  localparam int CNT_W          = 16;
  localparam int CH_W           = ch_idx_w(N_CH);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N_CH-1:0]   ch_progress = '0;
  logic [N_CH-1:0]   ch_done = '0;
  logic [N_CH-1:0]   ch_error = '0;
  logic              dut_rst;
  logic [2:0]        state;
  logic [CNT_W-1:0]  cycle_cnt;
  logic              finish;
  logic              pass;
  logic [1:0]        fail_code;
  logic [CH_W-1:0]   fail_ch;

  int n_checks = 0;
  int n_fail   = 0;

  sim_ctrl #(
    .N_CH           (N_CH),
    .RST_CYCLES     (RST_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .IDLE_CYCLES    (IDLE_CYCLES),
    .DRAIN_CYCLES   (DRAIN_CYCLES),
    .CNT_W          (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_progress (ch_progress),
    .ch_done     (ch_done),
    .ch_error    (ch_error),
    .dut_rst     (dut_rst),
    .state       (state),
    .cycle_cnt   (cycle_cnt),
    .finish      (finish),
    .pass        (pass),
    .fail_code   (fail_code),
    .fail_ch     (fail_ch)
  );

  always #5 clk = ~clk;

  // Reference model state
  state_t  m_phase;
  int      m_hold, m_drain, m_fc, m_fch;
  longint  m_cnt;
  bit      m_done [N_CH];
  int      m_idle [N_CH];
  bit      m_dutrst, m_finish, m_pass;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N_CH-1:0] rnd();
    return N_CH'($urandom);
  endfunction

  function automatic bit m_term();
    return (m_phase == PASS) || (m_phase == FAIL);
  endfunction

  task automatic model_fail(input int code, input int ch);
    m_phase  = FAIL;
    m_fc     = code;
    m_fch    = ch;
    m_finish = 1;
  endtask

  task automatic model_pass();
    m_phase  = PASS;
    m_pass   = 1;
    m_finish = 1;
  endtask

  task automatic model_step(input bit r, input logic [N_CH-1:0] p, input logic [N_CH-1:0] d,
                            input logic [N_CH-1:0] e);
    int     first_err, first_stall;
    bit     all_done, in_run;
    longint cnt_before;
    m_finish = 0;
    if (!r) begin
      m_phase = RST_HOLD; m_hold = 0; m_drain = 0; m_cnt = 0;
      m_dutrst = 0; m_pass = 0; m_fc = 0; m_fch = 0;
      for (int i = 0; i < N_CH; i++) begin
        m_done[i] = 0;
        m_idle[i] = 0;
      end
      return;
    end
    if (m_phase == RST_HOLD) begin
      m_hold++;
      if (m_hold == RST_CYCLES) begin
        m_phase  = RUN;
        m_dutrst = 1;
      end
      return;
    end
    if (m_term()) return;
    in_run      = (m_phase == RUN);
    cnt_before  = m_cnt;
    first_err   = -1;
    first_stall = -1;
    all_done    = 1;
    for (int i = 0; i < N_CH; i++) begin
      m_done[i] = m_done[i] | d[i];
      if (p[i] || m_done[i]) m_idle[i] = 0;
      else if (m_idle[i] < IDLE_CYCLES) m_idle[i]++;
      if (e[i] && first_err < 0) first_err = i;
      if (!m_done[i] && m_idle[i] == IDLE_CYCLES && first_stall < 0) first_stall = i;
      all_done &= m_done[i];
    end
    if (m_cnt < (longint'(1) << CNT_W) - 1) m_cnt++;
    if (first_err >= 0) model_fail(3, first_err);
    else if (in_run) begin
      if (first_stall >= 0) model_fail(2, first_stall);
      else if (cnt_before == TIMEOUT_CYCLES - 1) model_fail(1, 0);
      else if (all_done) begin
        if (DRAIN_CYCLES == 0) model_pass();
        else begin
          m_phase = DRAIN;
          m_drain = 0;
        end
      end
    end else begin
      m_drain++;
      if (m_drain == DRAIN_CYCLES) model_pass();
    end
  endtask

  task automatic check_all();
    chk("dut_rst",   32'(dut_rst),   32'(m_dutrst));
    chk("state",     32'(state),     32'(m_phase));
    chk("cycle_cnt", 32'(cycle_cnt), 32'(m_cnt));
    chk("finish",    32'(finish),    32'(m_finish));
    chk("pass",      32'(pass),      32'(m_pass));
    chk("fail_code", 32'(fail_code), 32'(m_fc));
    chk("fail_ch",   32'(fail_ch),   32'(m_fch));
  endtask

  task automatic step(input bit r, input logic [N_CH-1:0] p, input logic [N_CH-1:0] d,
                      input logic [N_CH-1:0] e);
    rst = r; ch_progress = p; ch_done = d; ch_error = e;
    @(posedge clk);
    model_step(r, p, d, e);
    #1 check_all();
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) step(1'b0, rnd(), rnd(), rnd());
    for (int i = 0; i < RST_CYCLES; i++) step(1'b1, rnd(), rnd(), rnd());
    chk("hold_to_run_state", 32'(state), 32'(RUN));
    chk("hold_to_run_dut_rst", 32'(dut_rst), 32'd1);
  endtask

  // Run cycle k: progress on ch i while k < ps_i, done pulse at k == d_i, error mask at err_at.
  task automatic run_directed(input int ps0, input int ps1, input int ps2,
                              input int d0, input int d1, input int d2,
                              input int err_at, input logic [N_CH-1:0] err_mask, input int rst_at);
    logic [N_CH-1:0] p, d, e;
    for (int k = 0; k < 400; k++) begin
      p = {k < ps2, k < ps1, k < ps0};
      d = {k == d2, k == d1, k == d0};
      e = (k == err_at) ? err_mask : '0;
      step(k != rst_at, p, d, e);
      if (k == rst_at || m_term()) break;
    end
    if (m_term()) begin
      for (int j = 0; j < 4; j++) step(1'b1, rnd(), rnd(), rnd());
    end
  endtask

  task automatic expect_end(input string tag, input state_t st, input int ps, input int fc,
                            input int fch, input int cnt);
    chk({tag, "_state"}, 32'(state), 32'(st));
    chk({tag, "_pass"}, 32'(pass), 32'(ps));
    chk({tag, "_fail_code"}, 32'(fail_code), 32'(fc));
    chk({tag, "_fail_ch"}, 32'(fail_ch), 32'(fch));
    chk({tag, "_cycle_cnt"}, 32'(cycle_cnt), 32'(cnt));
    chk({tag, "_finish_low"}, 32'(finish), 32'd0);
  endtask

  logic [N_CH-1:0] rp, rd, re;
  bit              rr;
  int              stop_k [N_CH];
  int              done_k [N_CH];

  initial begin
    step(1'b0, '0, '0, '0);
    chk("reset_state", 32'(state), 32'(RST_HOLD));
    chk("reset_dut_rst", 32'(dut_rst), 32'd0);

    // Clean pass: ch0 done at 50, ch2 at 60, ch1 at 70 -> drain from 71, pass at 87
    do_reset();
    run_directed(1000, 1000, 1000, 50, 70, 60, -1, '0, -1);
    expect_end("clean", PASS, 1, 0, 0, 87);

    // Stall on ch1 after progress stops at run cycle 10
    do_reset();
    run_directed(1000, 10, 1000, 5, -1, -1, -1, '0, -1);
    expect_end("stall", FAIL, 0, 2, 1, 30);

    // Global timeout
    do_reset();
    run_directed(1000, 1000, 1000, -1, -1, -1, -1, '0, -1);
    expect_end("timeout", FAIL, 0, 1, 0, 200);

    // Errors on ch0 and ch1 plus stall on ch0 in the same cycle
    do_reset();
    run_directed(0, 1000, 1000, -1, -1, -1, 19, 3'b011, -1);
    expect_end("prio", FAIL, 0, 3, 0, 20);

    // Error during drain
    do_reset();
    run_directed(12, 12, 12, 10, 10, 10, 15, 3'b100, -1);
    expect_end("drain_err", FAIL, 0, 3, 2, 16);

    // Error and all-done together
    do_reset();
    run_directed(1000, 1000, 1000, 12, 12, 12, 12, 3'b010, -1);
    expect_end("err_done", FAIL, 0, 3, 1, 13);

    // Drain crosses the timeout cycle count: timeout is masked
    do_reset();
    run_directed(1000, 1000, 1000, 195, 195, 195, -1, '0, -1);
    expect_end("drain_masks_to", PASS, 1, 0, 0, 212);

    // Timeout and all-done together
    do_reset();
    run_directed(1000, 1000, 1000, 199, 199, 199, -1, '0, -1);
    expect_end("to_done", FAIL, 0, 1, 0, 200);

    // Reset mid-run, then a clean rerun from the hold sequence
    do_reset();
    run_directed(1000, 1000, 1000, -1, -1, -1, -1, '0, 40);
    chk("midrst_state", 32'(state), 32'(RST_HOLD));
    chk("midrst_dut_rst", 32'(dut_rst), 32'd0);
    chk("midrst_cycle_cnt", 32'(cycle_cnt), 32'd0);
    for (int i = 0; i < RST_CYCLES; i++) begin
      step(1'b1, rnd(), rnd(), rnd());
      chk("rerun_hold_dut_rst", 32'(dut_rst), (i == RST_CYCLES - 1) ? 32'd1 : 32'd0);
    end
    run_directed(1000, 1000, 1000, 50, 70, 60, -1, '0, -1);
    expect_end("rerun", PASS, 1, 0, 0, 87);

    // Randomized runs
    for (int r = 0; r < 24; r++) begin
      do_reset();
      for (int i = 0; i < N_CH; i++) begin
        stop_k[i] = $urandom_range(0, 400);
        done_k[i] = $urandom_range(0, 260);
      end
      for (int k = 0; k < 400; k++) begin
        for (int i = 0; i < N_CH; i++) begin
          rp[i] = (k < stop_k[i]) && ($urandom_range(0, 99) < 90);
          rd[i] = (k == done_k[i]) || ($urandom_range(0, 199) == 0);
          re[i] = ($urandom_range(0, 1499) == 0);
        end
        rr = ($urandom_range(0, 599) != 0);
        step(rr, rp, rd, re);
        if (!rr || m_term()) break;
      end
      for (int j = 0; j < 3; j++) step(1'b1, rnd(), rnd(), rnd());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
